// File: rtl/stream_mux2_rr.sv
// -----------------------------------------------------------------------------
// stream_mux2_rr
//   Two-input stream multiplexer feeding a 2-entry output FIFO. Each buffered
//   word carries a source tag (ys) so a select-driven 1:2 demux downstream can
//   split the stream again.
//
//   Arbitration: round-robin between the two channels by default. Defining
//   the macro STREAM_MUX2_FIXED_PRI_EN selects fixed priority (channel 0 wins
//   ties) and removes the last-grant register.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   d0/v0  in   channel 0 data / valid;  r0 out  channel 0 ready
//   d1/v1  in   channel 1 data / valid;  r1 out  channel 1 ready
//   y      out  head data (0 when empty)
//   ys     out  head source tag (0 when empty)
//   vy     out  output valid (buffer not empty)
//   ry     in   output ready from consumer
//   occ    out  buffer occupancy, 0..2
// -----------------------------------------------------------------------------
module stream_mux2_rr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d0,
  input  logic         v0,
  output logic         r0,
  input  logic [W-1:0] d1,
  input  logic         v1,
  output logic         r1,
  output logic [W-1:0] y,
  output logic         ys,
  output logic         vy,
  input  logic         ry,
  output logic [1:0]   occ
);

  logic [W:0]   r_mem [2];
  logic         r_ptr_rd;
  logic         r_ptr_wr;
  logic [1:0]   r_occ;

  logic         w_full;
  logic         w_g0;
  logic         w_g1;
  logic         w_push;
  logic         w_pop;
  logic         w_vy;
  logic [W-1:0] w_din;
  logic [W:0]   w_head;

  // Ready depends only on registered occupancy; a pop at occ==2 does not
  // open a slot in the same cycle. rst_n gates readies so no handshake is
  // ever seen as accepted while reset is asserted.
  assign w_full = (r_occ == 2'd2);

`ifdef STREAM_MUX2_FIXED_PRI_EN
  assign w_g0 = rst_n & ~w_full & v0;
  assign w_g1 = rst_n & ~w_full & v1 & ~v0;
`else
  // r_last holds the channel granted most recently; on a tie the other
  // channel wins. Reset value 1 lets channel 0 win the first tie.
  logic r_last;

  assign w_g0 = rst_n & ~w_full & v0 & (~v1 | r_last);
  assign w_g1 = rst_n & ~w_full & v1 & (~v0 | ~r_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_g0 | w_g1) begin
      r_last <= w_g1;
    end
  end
`endif

  assign w_push = w_g0 | w_g1;
  assign w_vy   = (r_occ != 2'd0);
  assign w_pop  = w_vy & ry;
  assign w_din  = w_g1 ? d1 : d0;
  assign w_head = r_mem[r_ptr_rd];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_ptr_rd <= 1'b0;
      r_ptr_wr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_ptr_wr] <= {w_g1, w_din};
        r_ptr_wr        <= ~r_ptr_wr;
      end
      if (w_pop) begin
        r_ptr_rd <= ~r_ptr_rd;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign r0  = w_g0;
  assign r1  = w_g1;
  assign vy  = w_vy;
  assign y   = w_vy ? w_head[W-1:0] : '0;
  assign ys  = w_vy ? w_head[W]     : 1'b0;
  assign occ = r_occ;

endmodule

// File: tb/tb_stream_mux2_rr.sv
module tb_stream_mux2_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d0, d1, y;
  logic       v0, v1, r0, r1, ys, vy, ry;
  logic [1:0] occ;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  stream_mux2_rr #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .d0(d0), .v0(v0), .r0(r0),
    .d1(d1), .v1(v1), .r1(r1),
    .y(y), .ys(ys), .vy(vy), .ry(ry), .occ(occ)
  );

  // Reference model: FIFO contents as a queue of {tag, data}, plus the
  // channel that won most recently.
  logic [8:0] m_q[$];
  int         m_last = 1;
  logic       xfer0, xfer1;
  logic [8:0] popped[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // One clock: check outputs at the falling edge, advance the model at the
  // rising edge, then return 1 time unit after it so callers may drive.
  task automatic cycle();
    logic e_g0, e_g1, e_vy;
    logic [8:0] e_head;
    @(negedge clk);
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (rst_n && m_q.size() < 2) begin
      if (v0 && v1) begin
`ifdef STREAM_MUX2_FIXED_PRI_EN
        e_g0 = 1'b1;
`else
        if (m_last == 1) e_g0 = 1'b1; else e_g1 = 1'b1;
`endif
      end else begin
        e_g0 = v0;
        e_g1 = v1;
      end
    end
    e_vy   = (m_q.size() != 0);
    e_head = e_vy ? m_q[0] : 9'h000;
    chk("r0",  r0,  e_g0);
    chk("r1",  r1,  e_g1);
    chk("vy",  vy,  e_vy);
    chk("y",   y,   e_head[7:0]);
    chk("ys",  ys,  e_head[8]);
    chk("occ", occ, m_q.size());
    @(posedge clk);
    xfer0 = 1'b0;
    xfer1 = 1'b0;
    if (!rst_n) begin
      m_q.delete();
      m_last = 1;
    end else begin
      if (e_vy && ry) begin
        popped.push_back({ys, y});
        void'(m_q.pop_front());
      end
      if (e_g0) begin m_q.push_back({1'b0, d0}); m_last = 0; xfer0 = 1'b1; end
      if (e_g1) begin m_q.push_back({1'b1, d1}); m_last = 1; xfer1 = 1'b1; end
    end
    #1;
  endtask

  logic [8:0] exp_seq [4];

  initial begin
    rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 8'hA0; d1 = 8'hB0; ry = 1'b1;
    xfer0 = 1'b0; xfer1 = 1'b0;
    #1;
    repeat (3) cycle();
    chk("rst_occ", occ, 2'd0);
    chk("rst_y",   y,   8'h00);

    // Alternation with both channels always valid.
    rst_n = 1'b1;
    popped.delete();
    repeat (6) begin
      cycle();
      if (xfer0) d0 = d0 + 8'd1;
      if (xfer1) d1 = d1 + 8'd1;
    end
`ifdef STREAM_MUX2_FIXED_PRI_EN
    exp_seq = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h0A3};
`else
    exp_seq = '{9'h0A0, 9'h1B0, 9'h0A1, 9'h1B1};
`endif
    for (int i = 0; i < 4; i++) chk("alt_seq", popped[i], exp_seq[i]);
    chk("alt_occ", occ, 2'd1);

    // Drain, then fill under backpressure.
    v0 = 1'b0; v1 = 1'b0;
    repeat (3) cycle();
    ry = 1'b0; v0 = 1'b1; d0 = 8'h11;
    cycle();
    chk("bp_occ1", occ, 2'd1);
    d0 = 8'h22;
    cycle();
    chk("bp_occ2", occ, 2'd2);
    d0 = 8'h33;
    cycle();
    chk("bp_r0_full", r0, 1'b0);
    ry = 1'b1;
    popped.delete();
    cycle();
    chk("bp_pop", popped[0], 9'h011);
    chk("bp_occ_after", occ, 2'd1);
    ry = 1'b0;
    cycle();

    // Push and pop together at occ==1.
    v0 = 1'b0; ry = 1'b1;
    repeat (4) cycle();
    ry = 1'b0; v0 = 1'b1; d0 = 8'h44;
    cycle();
    v0 = 1'b0; v1 = 1'b1; d1 = 8'h5C; ry = 1'b1;
    cycle();
    chk("pp_occ", occ, 2'd1);
    chk("pp_ys",  ys,  1'b1);
    chk("pp_y",   y,   8'h5C);
    v1 = 1'b0;
    repeat (2) cycle();

    // Mid-stream reset with a full buffer.
    ry = 1'b0; v0 = 1'b1; v1 = 1'b1;
    repeat (3) cycle();
    chk("mr_full", occ, 2'd2);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; v0 = 1'b0; v1 = 1'b0; ry = 1'b1;
    chk("mr_occ", occ, 2'd0);
    chk("mr_vy",  vy,  1'b0);
    repeat (3) cycle();

    // Random traffic; senders hold valid/data until accepted.
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      ry    = ($urandom_range(0, 3) != 0);
      if (!v0 || xfer0) begin v0 = ($urandom_range(0, 2) != 0); d0 = 8'($urandom); end
      if (!v1 || xfer1) begin v1 = ($urandom_range(0, 2) != 0); d1 = 8'($urandom); end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_mux2_rr.md
# stream_mux2_rr

Two-input round-robin stream multiplexer with a 2-entry output buffer. It merges two valid/ready channels into one output stream and tags each word with a source-select bit `ys`. The tagged stream is the input format the team's select-driven 1:2 demultiplexer consumes, so this block sits at the merge end of a split/merge pair.

## Interface
Parameters:
- `W`, default 8: data width of every channel.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `d0`  in  W  channel 0 data.
- `v0`  in  1  channel 0 valid.
- `r0`  out  1  channel 0 ready.
- `d1`  in  W  channel 1 data.
- `v1`  in  1  channel 1 valid.
- `r1`  out  1  channel 1 ready.
- `y`  out  W  output data, taken from the buffer head.
- `ys`  out  1  output source tag, also from the buffer head: 0 means the word came from channel 0, 1 means channel 1.
- `vy`  out  1  output valid.
- `ry`  in  1  output ready, driven by the downstream consumer.
- `occ`  out  2  buffer occupancy, range 0 to 2.

## Operation
- A transfer happens on any channel where valid and ready are both 1 at a rising edge. Senders hold data and valid stable until the transfer completes.
- Buffer: 2-entry FIFO, each entry is {sel, data}.
  - Push: an input transfer.
  - Pop: `vy & ry`.
  - `occ` is the registered entry count.
- Grant, computed combinationally each cycle:
  - If `occ == 2`, nothing is granted and `r0 = r1 = 0`.
  - Otherwise, with only one channel valid, that channel is granted.
  - With both valid, the channel not equal to `last` is granted (round-robin).
  - With neither valid, nothing is granted.
  - The granted channel's ready is 1; the other ready is 0.
  - When nothing is valid and `occ < 2`, `r0 = r1 = 0`. Ready is never asserted without the matching valid.
- `last` register: updated to the granted channel on every accepted transfer; unchanged otherwise.
- Outputs: `vy = (occ != 0)`. `y` and `ys` are the head entry when `vy = 1`, and 0 when `occ == 0`.
- Occupancy update:
  - Push only: `occ + 1`.
  - Pop only: `occ - 1`.
  - Push and pop together: `occ` unchanged, head advances, new entry written.
  - Neither: unchanged.
- Full condition: ready is derived from registered `occ` only, never from `ry`. At `occ == 2`, a pop this cycle does not enable a push this cycle.
- Entries leave in push order. Entry order is never reordered.

## Timing
- Reset: while `rst_n` is low at a rising edge, the following take effect after that edge:
  - `occ = 0`, `vy = 0`, `y = 0`, `ys = 0`.
  - `last = 1`, so channel 0 wins the first tie.
  - Buffer pointers are 0.
  - `r0 = r1 = 0` in every cycle where `rst_n` is sampled low.
- Reset mid-operation: buffered words are discarded with no pop. Any in-flight input handshake is not accepted.
- Latency: a word accepted at edge N appears on `y`/`ys` with `vy = 1` after edge N, provided the buffer was empty.
- Throughput: with `ry` held at 1, one word per cycle is sustained and `occ` stays at 1. With both inputs always valid, grants alternate 0, 1, 0, 1, ...
- Backpressure: with `ry` low, at most 2 words are accepted, then both readies drop. Readies reassert the cycle after the first pop.
- Pointer wrap: read and write pointers are 1 bit each and wrap 1 → 0.

## Configuration
- `STREAM_MUX2_FIXED_PRI_EN`:
  - Defined: fixed priority. When both channels are valid, channel 0 always wins, and the `last` register is not implemented.
  - Undefined (default): round-robin as described in Operation.
  - All other behaviour is identical in both builds.

## Test plan
- Reset: hold `rst_n = 0` for 3 cycles with `v0 = v1 = 1` → `r0 = r1 = 0`, `vy = 0`, `occ = 0`, `y = 0`. After release, the first grant goes to channel 0.
- Alternation: drive `v0 = v1 = 1`, `ry = 1`, `d0 = 0xA0` upward, `d1 = 0xB0` upward → output sequence (`ys`, `y`) = (0,A0), (1,B0), (0,A1), (1,B1); `occ` stays at 1.
- Full/backpressure: `ry = 0`, `v0 = 1`, `d0 = 0x11`, then `0x22` → `occ` = 1, then 2, then `r0 = 0`. Raise `ry` for one cycle → `y = 0x11` pops, `occ = 1`, `r0 = 1` on the following cycle.
- Simultaneous push and pop at `occ = 1`: `d1 = 0x5C` accepted while `ry = 1` → `occ` stays 1, and the next head is `ys = 1`, `y = 0x5C`.
- Mid-stream reset: `occ = 2`, then `rst_n = 0` for 1 cycle → `occ = 0`, `vy = 0`. No stale data appears after release.
- With `STREAM_MUX2_FIXED_PRI_EN` defined: `v0 = v1 = 1`, `ry = 1` for 4 cycles → `ys = 0` every cycle and `r1` never asserts.
